// File: rtl/lc2k_pkg.sv
// Shared encodings for the LC2K multi-cycle controller and its datapath:
// opcodes, sequencer states, ALU / PC / write-data mux selects, and the
// bundle of per-cycle control strobes.
package lc2k_pkg;

  // Opcode field IR[24:22]
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_NOOP = 3'd7;

  // Sequencer states
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  // ALU operation select
  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_NOR = 2'b01;
  localparam logic [1:0] ALU_OP_EQ  = 2'b10;

  // PC source select
  localparam logic [1:0] PC_SRC_INC  = 2'b00;  // PC+1
  localparam logic [1:0] PC_SRC_BR   = 2'b01;  // PC+1+offset
  localparam logic [1:0] PC_SRC_REGA = 2'b10;  // regA (jalr)

  // Regfile write-data select
  localparam logic [1:0] WDATA_MEM = 2'b00;
  localparam logic [1:0] WDATA_ALU = 2'b01;
  localparam logic [1:0] WDATA_PC1 = 2'b10;

  // Every strobe/select the controller drives in one cycle
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       write_reg_sel;
    logic [1:0] write_data_sel;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       fault;
  } ctrl_t;

  // ALU B operand: regB for register-register ops and beq, offset for lw/sw
  function automatic logic alu_src_b_for(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_NOR) || (op == OP_BEQ);
  endfunction

  function automatic logic [1:0] alu_op_for(input logic [2:0] op);
    case (op)
      OP_NOR:  return ALU_OP_NOR;
      OP_BEQ:  return ALU_OP_EQ;
      default: return ALU_OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/lc2k_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The master side is the
// controller; the slave side is the datapath plus unified memory.
interface lc2k_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [2:0]       opcode;
  logic             alu_eq;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic             write_reg_sel;
  logic [1:0]       write_data_sel;
  logic             alu_srcB;
  logic [1:0]       alu_op;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, alu_eq, mem_ack,
    output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
           reg_write, write_reg_sel, write_data_sel, alu_srcB, alu_op,
           halted, fault, instr_count
  );

  modport slave (
    output opcode, alu_eq, mem_ack,
    input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
           reg_write, write_reg_sel, write_data_sel, alu_srcB, alu_op,
           halted, fault, instr_count
  );
endinterface

// File: rtl/lc2k_mem_wait_timer.sv
// Counts consecutive request cycles without an acknowledge and raises
// timeout in the cycle where the WAIT_LIMIT-th such cycle is reached.
module lc2k_mem_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

  logic [CW-1:0] cnt_q;

  // Wait counter: cleared by idle or ack, saturates at the timeout value
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n)
      cnt_q <= '0;
    else if (!req || ack)
      cnt_q <= '0;
    else if (cnt_q != LAST)
      cnt_q <= cnt_q + CW'(1);
  end

  assign timeout = req && !ack && (cnt_q == LAST);

endmodule

// File: rtl/lc2k_multicycle_ctrl.sv
// Multi-cycle LC2K sequencer: FETCH/DECODE/EXEC/MEM/WB with absorbing
// HALT and FAULT states, per-cycle datapath strobes decoded from the
// current state, and a retired-instruction counter.
module lc2k_multicycle_ctrl
  import lc2k_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lc2k_multicycle_ctrl_if.master bus
);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  logic             retire;
  ctrl_t            ctrl;

  lc2k_mem_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ctrl.mem_req),
    .ack     (bus.mem_ack),
    .timeout (timeout)
  );

  // Next state and control strobes from state, latched opcode, ack and compare
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (bus.mem_ack) begin
          ctrl.ir_write = 1'b1;
          state_d       = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        // op_q is loaded at the end of this cycle, so decode the live IR field
        case (bus.opcode)
          OP_HALT: state_d = ST_HALT;
          OP_NOOP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_SRC_INC;
            state_d       = ST_FETCH;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        ctrl.alu_src_b = alu_src_b_for(op_q);
        ctrl.alu_op    = alu_op_for(op_q);
        case (op_q)
          OP_ADD, OP_NOR: state_d = ST_WB;
          OP_LW, OP_SW:   state_d = ST_MEM;
          OP_BEQ: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = bus.alu_eq ? PC_SRC_BR : PC_SRC_INC;
            state_d       = ST_FETCH;
          end
          OP_JALR: begin
            // regB gets old PC+1 and PC gets regA on the same edge
            ctrl.reg_write      = 1'b1;
            ctrl.write_reg_sel  = 1'b0;
            ctrl.write_data_sel = WDATA_PC1;
            ctrl.pc_write       = 1'b1;
            ctrl.pc_src         = PC_SRC_REGA;
            state_d             = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
        ctrl.mem_we       = (op_q == OP_SW);
        ctrl.alu_src_b    = alu_src_b_for(op_q);
        ctrl.alu_op       = alu_op_for(op_q);
        if (bus.mem_ack) begin
          if (op_q == OP_LW) begin
            state_d = ST_WB;
          end else begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_SRC_INC;
            state_d       = ST_FETCH;
          end
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        ctrl.reg_write = 1'b1;
        if (op_q == OP_LW) begin
          ctrl.write_reg_sel  = 1'b0;
          ctrl.write_data_sel = WDATA_MEM;
        end else begin
          ctrl.write_reg_sel  = 1'b1;
          ctrl.write_data_sel = WDATA_ALU;
        end
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_SRC_INC;
        state_d       = ST_FETCH;
      end
      ST_HALT:  ctrl.halted = 1'b1;
      ST_FAULT: ctrl.fault  = 1'b1;
      default:  state_d = ST_FETCH;
    endcase
    // Everything is quiet while reset is held
    if (!rst_n) begin
      ctrl    = '0;
      state_d = ST_FETCH;
    end
  end

  // An instruction retires when its last working state hands back to FETCH,
  // or when halt is decoded
  assign retire = ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                   (state_q == ST_MEM)    || (state_q == ST_WB)) &&
                  ((state_d == ST_FETCH)  || (state_d == ST_HALT));

  // State, latched opcode and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE)
        op_q <= bus.opcode;
      if (retire)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.mem_req        = ctrl.mem_req;
  assign bus.mem_we         = ctrl.mem_we;
  assign bus.mem_addr_sel   = ctrl.mem_addr_sel;
  assign bus.ir_write       = ctrl.ir_write;
  assign bus.pc_write       = ctrl.pc_write;
  assign bus.pc_src         = ctrl.pc_src;
  assign bus.reg_write      = ctrl.reg_write;
  assign bus.write_reg_sel  = ctrl.write_reg_sel;
  assign bus.write_data_sel = ctrl.write_data_sel;
  assign bus.alu_srcB       = ctrl.alu_src_b;
  assign bus.alu_op         = ctrl.alu_op;
  assign bus.halted         = ctrl.halted;
  assign bus.fault          = ctrl.fault;
  assign bus.instr_count    = rst_n ? cnt_q : '0;

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Directed bench for the LC2K multi-cycle controller. A cycle-by-cycle
// vector table walks add, lw (with waits), beq taken/not taken, sw, jalr,
// nor and noop; hand sequences cover halt, memory timeout and reset mid-MEM.
module tb_lc2k_multicycle_ctrl;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       asel;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic       wrs;
    logic [1:0] wds;
    logic       srcb;
    logic [1:0] aop;
    logic       hlt;
    logic       flt;
  } outs_t;

  typedef struct {
    logic        rst;
    logic [2:0]  op;
    logic        eq;
    logic        ack;
    outs_t       exp;
    int unsigned cnt;
  } vec_t;

  localparam int WAIT_LIMIT = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  lc2k_multicycle_ctrl_if #(.CNT_W(32)) bus ();

  lc2k_multicycle_ctrl #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t o(input logic req, we, asel, irw, pcw,
                              input logic [1:0] pcs, input logic rw, wrs,
                              input logic [1:0] wds, input logic srcb,
                              input logic [1:0] aop, input logic hlt, flt);
    outs_t r;
    r = '{req, we, asel, irw, pcw, pcs, rw, wrs, wds, srcb, aop, hlt, flt};
    return r;
  endfunction

  function automatic outs_t sample();
    outs_t r;
    r = '{bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_write,
          bus.pc_write, bus.pc_src, bus.reg_write, bus.write_reg_sel,
          bus.write_data_sel, bus.alu_srcB, bus.alu_op, bus.halted, bus.fault};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare on the falling edge, advance to
  // just past the next rising edge
  task automatic apply(input string name, input logic r, input logic [2:0] op,
                       input logic eq, input logic ack, input outs_t exp,
                       input int unsigned cnt);
    rst_n       = r;
    bus.opcode  = op;
    bus.alu_eq  = eq;
    bus.mem_ack = ack;
    @(negedge clk);
    check({name, " strobes"}, 64'(sample()), 64'(exp));
    check({name, " count"}, 64'(bus.instr_count), 64'(cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic r, input logic [2:0] op, input logic eq,
                         input logic ack, input outs_t exp,
                         input int unsigned cnt);
    vec_t v;
    v.rst = r; v.op = op; v.eq = eq; v.ack = ack; v.exp = exp; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    outs_t z, f_req, f_ack, m_rd;
    n_checks = 0;
    n_fail   = 0;
    rst_n       = 1'b0;
    bus.opcode  = 3'd0;
    bus.alu_eq  = 1'b0;
    bus.mem_ack = 1'b0;

    z     = o(0,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,0,0);
    f_req = o(1,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,0,0);
    f_ack = o(1,0,0,1,0,2'd0,0,0,2'd0,0,2'd0,0,0);
    m_rd  = o(1,0,1,0,0,2'd0,0,0,2'd0,0,2'd0,0,0);

    // reset held with ack high: everything zero
    add_vec(0, 3'd0, 0, 1, z, 0);
    // add, zero-wait (ack in DECODE ignored)
    add_vec(1, 3'd0, 0, 1, f_ack, 0);
    add_vec(1, 3'd0, 0, 1, z, 0);
    add_vec(1, 3'd0, 0, 0, o(0,0,0,0,0,2'd0,0,0,2'd0,1,2'd0,0,0), 0);
    add_vec(1, 3'd0, 0, 0, o(0,0,0,0,1,2'd0,1,1,2'd1,0,2'd0,0,0), 0);
    // lw: one fetch wait, three MEM waits then ack
    add_vec(1, 3'd2, 0, 0, f_req, 1);
    add_vec(1, 3'd2, 0, 1, f_ack, 1);
    add_vec(1, 3'd2, 0, 0, z, 1);
    add_vec(1, 3'd2, 0, 1, z, 1);
    add_vec(1, 3'd2, 0, 0, m_rd, 1);
    add_vec(1, 3'd2, 0, 0, m_rd, 1);
    add_vec(1, 3'd2, 0, 0, m_rd, 1);
    add_vec(1, 3'd2, 0, 1, m_rd, 1);
    add_vec(1, 3'd2, 0, 0, o(0,0,0,0,1,2'd0,1,0,2'd0,0,2'd0,0,0), 1);
    // beq taken
    add_vec(1, 3'd4, 1, 1, f_ack, 2);
    add_vec(1, 3'd4, 1, 0, z, 2);
    add_vec(1, 3'd4, 1, 0, o(0,0,0,0,1,2'd1,0,0,2'd0,1,2'd2,0,0), 2);
    // beq not taken
    add_vec(1, 3'd4, 0, 1, f_ack, 3);
    add_vec(1, 3'd4, 0, 0, z, 3);
    add_vec(1, 3'd4, 0, 0, o(0,0,0,0,1,2'd0,0,0,2'd0,1,2'd2,0,0), 3);
    // sw, zero-wait
    add_vec(1, 3'd3, 0, 1, f_ack, 4);
    add_vec(1, 3'd3, 0, 0, z, 4);
    add_vec(1, 3'd3, 0, 0, z, 4);
    add_vec(1, 3'd3, 0, 1, o(1,1,1,0,1,2'd0,0,0,2'd0,0,2'd0,0,0), 4);
    // jalr
    add_vec(1, 3'd5, 1, 1, f_ack, 5);
    add_vec(1, 3'd5, 1, 0, z, 5);
    add_vec(1, 3'd5, 1, 0, o(0,0,0,0,1,2'd2,1,0,2'd2,0,2'd0,0,0), 5);
    // nor
    add_vec(1, 3'd1, 0, 1, f_ack, 6);
    add_vec(1, 3'd1, 0, 0, z, 6);
    add_vec(1, 3'd1, 0, 0, o(0,0,0,0,0,2'd0,0,0,2'd0,1,2'd1,0,0), 6);
    add_vec(1, 3'd1, 0, 0, o(0,0,0,0,1,2'd0,1,1,2'd1,0,2'd0,0,0), 6);
    // noop retires in DECODE
    add_vec(1, 3'd7, 0, 1, f_ack, 7);
    add_vec(1, 3'd7, 0, 0, o(0,0,0,0,1,2'd0,0,0,2'd0,0,2'd0,0,0), 7);
    add_vec(1, 3'd7, 0, 0, f_req, 8);

    @(posedge clk);
    #1;
    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].eq,
            vecs[i].ack, vecs[i].exp, vecs[i].cnt);

    // halt: halted from the third cycle, strobes silent, one retire
    apply("halt fetch", 1, 3'd6, 0, 1, f_ack, 8);
    apply("halt decode", 1, 3'd6, 0, 0, z, 8);
    for (int i = 0; i < 20; i++)
      apply($sformatf("halt hold%0d", i), 1, 3'd6, 0, 1'(i % 2),
            o(0,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,1,0), 9);

    // reset out of HALT
    apply("reset from halt", 0, 3'd0, 0, 1, z, 0);

    // timeout: four unacknowledged fetch cycles, then absorbing fault
    for (int i = 0; i < WAIT_LIMIT; i++)
      apply($sformatf("fault wait%0d", i), 1, 3'd0, 0, 0, f_req, 0);
    for (int i = 0; i < 3; i++)
      apply($sformatf("fault hold%0d", i), 1, 3'd0, 0, 1,
            o(0,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,0,1), 0);

    // reset out of FAULT, then lw stalled in MEM and reset mid-request
    apply("reset from fault", 0, 3'd0, 0, 0, z, 0);
    apply("midmem fetch", 1, 3'd2, 0, 1, f_ack, 0);
    apply("midmem decode", 1, 3'd2, 0, 0, z, 0);
    apply("midmem exec", 1, 3'd2, 0, 0, z, 0);
    apply("midmem mem0", 1, 3'd2, 0, 0, m_rd, 0);
    apply("midmem mem1", 1, 3'd2, 0, 0, m_rd, 0);
    apply("midmem reset", 0, 3'd2, 0, 1, z, 0);
    apply("post reset fetch", 1, 3'd7, 0, 0, f_req, 0);
    apply("post reset ack", 1, 3'd7, 0, 1, f_ack, 0);
    apply("post reset noop", 1, 3'd7, 0, 0,
          o(0,0,0,0,1,2'd0,0,0,2'd0,0,2'd0,0,0), 0);
    apply("post reset retire", 1, 3'd7, 0, 0, f_req, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
